// File: rtl/pc_sequencer.sv
// pc_sequencer: PC control FSM (start/fetch/exec/load/halt), optional fetch-timeout FAULT state under PC_SEQ_TIMEOUT_EN
module pc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic notReset,
  input  logic memReady,
  input  logic stall,
  input  logic execDone,
  input  logic jump,
  input  logic halt,
  output logic pcNotReset,
  output logic pcNotLoad,
  output logic pcInc,
  output logic pcNotOE,
  output logic memRead,
  output logic irLoad,
  output logic execStart,
  output logic halted,
  output logic fault
);
`ifdef PC_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {START, FETCH, EXEC, LOAD, HALTED, FAULT} state_t;
`else
  typedef enum logic [2:0] {START, FETCH, EXEC, LOAD, HALTED} state_t;
`endif
  state_t state;
  logic fetch_go;
  logic capture;
  assign fetch_go = state == FETCH && !stall;
  assign capture = fetch_go && memReady;
`ifdef PC_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic timeout;
  assign timeout = fetch_go && !memReady && wait_cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or negedge notReset)
    if (!notReset) wait_cnt <= '0;
    else wait_cnt <= (fetch_go && !memReady) ? wait_cnt + 8'd1 : 8'd0;
  assign fault = state == FAULT;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT_CYCLES);
  assign fault = 1'b0;
`endif
  always_ff @(posedge clock or negedge notReset)
    if (!notReset) state <= START;
    else
      case (state)
        START:   state <= FETCH;
`ifdef PC_SEQ_TIMEOUT_EN
        FETCH:   state <= capture ? EXEC : timeout ? FAULT : FETCH;
`else
        FETCH:   state <= capture ? EXEC : FETCH;
`endif
        EXEC:    state <= !execDone ? EXEC : halt ? HALTED : jump ? LOAD : FETCH;
        LOAD:    state <= FETCH;
        default: state <= state;
      endcase
  assign pcNotReset = state != START;
  assign pcNotLoad = state != LOAD;
  assign pcInc = capture;
  assign pcNotOE = !fetch_go;
  assign memRead = fetch_go;
  assign irLoad = capture;
  assign execStart = state == EXEC;
  assign halted = state == HALTED;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: random + directed check of pc_sequencer against a phase/PC model
module tb_pc_sequencer;
  localparam int T = 4;
`ifdef PC_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int P_START = 0, P_FETCH = 1, P_EXEC = 2, P_LOAD = 3, P_HALT = 4, P_FAULT = 5;
  logic clock = 1'b0;
  logic notReset = 1'b1;
  logic memReady = 1'b0, stall = 1'b0, execDone = 1'b0, jump = 1'b0, halt = 1'b0;
  logic pcNotReset, pcNotLoad, pcInc, pcNotOE, memRead, irLoad, execStart, halted, fault;
  logic [15:0] bus = 16'h0;
  logic [15:0] pc;
  logic [15:0] mpc = 16'h0;
  int ph = P_START;
  int wcnt = 0;
  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;
  pc_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .notReset(notReset), .memReady(memReady), .stall(stall),
    .execDone(execDone), .jump(jump), .halt(halt), .pcNotReset(pcNotReset),
    .pcNotLoad(pcNotLoad), .pcInc(pcInc), .pcNotOE(pcNotOE), .memRead(memRead),
    .irLoad(irLoad), .execStart(execStart), .halted(halted), .fault(fault)
  );
  always #5 clock = ~clock;
  always @(posedge clock)
    if (!pcNotReset) pc <= 16'h0;
    else if (!pcNotLoad) pc <= bus;
    else if (pcInc) pc <= pc + 16'h1;
  function automatic logic [8:0] expect_out(int p, logic s, logic r);
    logic nrst = 1'b1, nld = 1'b1, inc = 1'b0, noe = 1'b1, rd = 1'b0;
    logic ir = 1'b0, xs = 1'b0, hl = 1'b0, ft = 1'b0;
    if (p == P_START) nrst = 1'b0;
    if (p == P_FETCH && !s) begin
      noe = 1'b0;
      rd = 1'b1;
      ir = r;
      inc = r;
    end
    if (p == P_EXEC) xs = 1'b1;
    if (p == P_LOAD) nld = 1'b0;
    if (p == P_HALT) hl = 1'b1;
    if (p == P_FAULT) ft = 1'b1;
    return {nrst, nld, inc, noe, rd, ir, xs, hl, ft};
  endfunction
  always @(posedge clock) begin
    logic [8:0] e;
    e = expect_out(ph, stall, memReady);
    if (!e[8]) mpc = 16'h0;
    else if (!e[7]) mpc = bus;
    else if (e[6]) mpc = mpc + 16'h1;
    if (!notReset) begin
      ph = P_START;
      wcnt = 0;
    end else if (ph == P_START) begin
      ph = P_FETCH;
      wcnt = 0;
    end else if (ph == P_FETCH) begin
      if (stall) wcnt = 0;
      else if (memReady) begin
        ph = P_EXEC;
        wcnt = 0;
      end else begin
        wcnt++;
        if (TO_EN && wcnt >= T) ph = P_FAULT;
      end
    end else if (ph == P_EXEC) begin
      if (execDone) ph = halt ? P_HALT : jump ? P_LOAD : P_FETCH;
    end else if (ph == P_LOAD) ph = P_FETCH;
  end
  always @(negedge notReset) begin
    ph = P_START;
    wcnt = 0;
  end
  always @(negedge clock)
    if (chk_on) begin
      logic [8:0] e, g;
      e = expect_out(ph, stall, memReady);
      g = {pcNotReset, pcNotLoad, pcInc, pcNotOE, memRead, irLoad, execStart, halted, fault};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t phase=%0d got=%b want=%b", $time, ph, g, e);
      end
      vectors++;
      if (pc !== mpc) begin
        miscompares++;
        $display("FAIL pc t=%0t got=%h want=%h", $time, pc, mpc);
      end
    end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0h want=%0h", n, $time, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    #1 notReset = 1'b0;
    memReady = 1'b1;
    execDone = 1'b1;
    tick();
    tick();
    chk_on = 1'b1;
    tick();
    notReset = 1'b1;
    @(negedge clock);
    chk("start_clear", 32'(pcNotReset), 0);
    chk("start_no_fetch", 32'(memRead), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("fetch_oe", 32'(pcNotOE), 0);
      chk("fetch_inc", 32'(pcInc), 1);
      chk("fetch_pc", 32'(pc), i);
      @(negedge clock);
      chk("exec_start", 32'(execStart), 1);
    end
    tick();
    tick();
    jump = 1'b1;
    bus = 16'h1234;
    @(negedge clock);
    chk("jump_at_pc", 32'(pc), 32'h5);
    tick();
    jump = 1'b0;
    @(negedge clock);
    chk("load_pulse", 32'(pcNotLoad), 0);
    chk("load_no_inc", 32'(pcInc), 0);
    tick();
    @(negedge clock);
    chk("jump_target", 32'(pc), 32'h1234);
    tick();
    @(negedge clock);
    chk("jump_next", 32'(pc), 32'h1235);
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stall_ir", 32'(irLoad), 0);
      chk("stall_inc", 32'(pcInc), 0);
      chk("stall_oe", 32'(pcNotOE), 1);
      tick();
    end
    stall = 1'b0;
    @(negedge clock);
    chk("unstall_capture", 32'(irLoad), 1);
    tick();
    halt = 1'b1;
    jump = 1'b1;
    tick();
    halt = 1'b0;
    jump = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("halted", 32'(halted), 1);
      chk("halt_no_load", 32'(pcNotLoad), 1);
      chk("halt_pc", 32'(pc), 32'h1236);
      tick();
    end
    notReset = 1'b0;
    #1;
    chk("halt_reset_clear", 32'(pcNotReset), 0);
    chk("halt_reset_exit", 32'(halted), 0);
    tick();
    tick();
    notReset = 1'b1;
    tick();
    jump = 1'b1;
    bus = 16'hBEEF;
    tick();
    tick();
    jump = 1'b0;
    #2;
    chk("midload_active", 32'(pcNotLoad), 0);
    notReset = 1'b0;
    #1;
    chk("midload_abort", 32'(pcNotLoad), 1);
    chk("midload_clear", 32'(pcNotReset), 0);
    tick();
    tick();
    notReset = 1'b1;
    @(negedge clock);
    chk("midload_pc", 32'(pc), 0);
    if (TO_EN) begin
      tick();
      notReset = 1'b0;
      tick();
      memReady = 1'b0;
      execDone = 1'b0;
      notReset = 1'b1;
      tick();
      for (int k = 0; k < T; k++) begin
        @(negedge clock);
        chk("wait_no_fault", 32'(fault), 0);
        tick();
      end
      @(negedge clock);
      chk("timeout_fault", 32'(fault), 1);
      tick();
      notReset = 1'b0;
      tick();
      notReset = 1'b1;
      tick();
      for (int k = 0; k < T - 1; k++) begin
        @(negedge clock);
        chk("wait_no_ir", 32'(irLoad), 0);
        tick();
      end
      memReady = 1'b1;
      @(negedge clock);
      chk("limit_capture", 32'(irLoad), 1);
      tick();
      @(negedge clock);
      chk("limit_no_fault", 32'(fault), 0);
      chk("limit_exec", 32'(execStart), 1);
    end
    for (int i = 0; i < 3000; i++) begin
      tick();
      stall = ($urandom_range(3) == 0);
      memReady = $urandom_range(1);
      execDone = ($urandom_range(4) < 2);
      jump = ($urandom_range(9) < 3);
      halt = ($urandom_range(15) == 0);
      bus = 16'($urandom);
      if (!notReset) notReset = 1'b1;
      else if ($urandom_range(63) == 0 || ((ph == P_HALT || ph == P_FAULT) && $urandom_range(7) == 0))
        notReset = 1'b0;
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
